// File: rtl/vectored_interrupt_controller.sv
// rtl/vectored_interrupt_controller.sv - vectored, nested, fixed-priority interrupt controller
// Overrides the PC on ISR entry and keeps a saved-PC/active-ID stack for rfi.
module vectored_interrupt_controller #(
    parameter int                    NUM_IRQ       = 8,
    parameter int                    PC_WIDTH      = 11,
    parameter logic [PC_WIDTH-1:0]   VECTOR_BASE   = 'h4,
    parameter int                    VECTOR_STRIDE = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR  = 'h0,
    parameter logic [1:0]            PC_SAVE       = 2'h3,
    parameter int                    NEST_DEPTH    = 2,
    localparam int                   IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int                   DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic                instr_clock,
    input  logic                reset_n,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_mask_we,
    input  logic [NUM_IRQ-1:0]  irq_mask_wdata,
    output logic [NUM_IRQ-1:0]  irq_mask,
    output logic [NUM_IRQ-1:0]  irq_pending,
    input  logic [1:0]          pc_mux_control,
    input  logic [PC_WIDTH-1:0] pc_next,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_save,
    output logic                in_isr,
    output logic [IW-1:0]       active_id,
    output logic [DW-1:0]       nest_depth
);

    localparam logic [DW-1:0] MAX_DEPTH = DW'(NEST_DEPTH);

    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  pending;
    logic [NUM_IRQ-1:0]  mask;
    logic [DW-1:0]       depth;
    logic                entered_q;
    logic [PC_WIDTH-1:0] pc_stack [NEST_DEPTH];
    logic [IW-1:0]       id_stack [NEST_DEPTH];

    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  req;
    logic [NUM_IRQ-1:0]  pending_n;
    logic [IW-1:0]       cand_id;
    logic                cand_valid;
    logic [IW-1:0]       top_id;
    logic [PC_WIDTH-1:0] top_pc;
    logic                eligible;
    logic                rfi;
    logic                take;
    logic                pop;
    logic [PC_WIDTH-1:0] vector;

    assign rise = irq & ~irq_q;
    assign req  = pending & mask;
    assign rfi  = (pc_mux_control == PC_SAVE);

    // Descending scan so the lowest index, the highest priority, wins.
    always_comb begin
        cand_id    = '0;
        cand_valid = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) cand_id = IW'(i);
        end
    end

    always_comb begin
        top_id = '0;
        top_pc = RESET_VECTOR;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (DW'(k + 1) == depth) begin
                top_id = id_stack[k];
                top_pc = pc_stack[k];
            end
        end
    end

    assign eligible = cand_valid && (depth < MAX_DEPTH) &&
                      ((depth == '0) || (cand_id < top_id));
    assign take     = eligible && !entered_q && !rfi;
    assign pop      = rfi && (depth != '0);
    assign vector   = VECTOR_BASE + PC_WIDTH'(cand_id) * PC_WIDTH'(VECTOR_STRIDE);

    // A fresh edge on the line being entered survives the clear.
    always_comb begin
        pending_n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            pending_n[i] = rise[i] | (pending[i] & ~(take && (cand_id == IW'(i))));
        end
    end

    always_ff @(posedge instr_clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_q     <= '0;
            pending   <= '0;
            mask      <= '1;
            depth     <= '0;
            entered_q <= 1'b0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                pc_stack[k] <= '0;
                id_stack[k] <= '0;
            end
        end else begin
            irq_q     <= irq;
            pending   <= pending_n;
            entered_q <= take;
            if (irq_mask_we) mask <= irq_mask_wdata;
            if (take) begin
                depth <= depth + DW'(1);
            end else if (pop) begin
                depth <= depth - DW'(1);
            end
            for (int k = 0; k < NEST_DEPTH; k++) begin
                if (take && (DW'(k) == depth)) begin
                    pc_stack[k] <= pc_next;
                    id_stack[k] <= cand_id;
                end else if (pop && (DW'(k + 1) == depth)) begin
                    pc_stack[k] <= '0;
                    id_stack[k] <= '0;
                end
            end
        end
    end

    assign irq_mask    = mask;
    assign irq_pending = pending;
    assign pc_out      = take ? vector : pc_next;
    assign pc_save     = top_pc;
    assign in_isr      = (depth != '0);
    assign active_id   = top_id;
    assign nest_depth  = depth;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// tb/tb_vectored_interrupt_controller.sv - directed self-checking bench for vectored_interrupt_controller
module tb_vectored_interrupt_controller;

    logic        instr_clock;
    logic        reset_n;
    logic [7:0]  irq;
    logic        irq_mask_we;
    logic [7:0]  irq_mask_wdata;
    logic [7:0]  irq_mask;
    logic [7:0]  irq_pending;
    logic [1:0]  pc_mux_control;
    logic [10:0] pc_next;
    logic [10:0] pc_out;
    logic [10:0] pc_save;
    logic        in_isr;
    logic [2:0]  active_id;
    logic [1:0]  nest_depth;

    int pass_cnt  = 0;
    int check_cnt = 0;

    vectored_interrupt_controller dut (
        .instr_clock    (instr_clock),
        .reset_n        (reset_n),
        .irq            (irq),
        .irq_mask_we    (irq_mask_we),
        .irq_mask_wdata (irq_mask_wdata),
        .irq_mask       (irq_mask),
        .irq_pending    (irq_pending),
        .pc_mux_control (pc_mux_control),
        .pc_next        (pc_next),
        .pc_out         (pc_out),
        .pc_save        (pc_save),
        .in_isr         (in_isr),
        .active_id      (active_id),
        .nest_depth     (nest_depth)
    );

    initial instr_clock = 1'b0;
    always #5 instr_clock = ~instr_clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic step();
        @(negedge instr_clock);
    endtask

    task automatic enter(input int id, input logic [10:0] pcn, input logic [10:0] vec);
        step();
        irq = 8'(1 << id);
        pc_next = pcn;
        step();
        irq = '0;
        #1;
        check("enter_vec", 32'(pc_out), 32'(vec));
        step();
        #1;
        check("enter_id", 32'(active_id), id);
    endtask

    task automatic rfi(input logic [10:0] exp_save);
        step();
        pc_mux_control = 2'h3;
        #1;
        check("rfi_save", 32'(pc_save), 32'(exp_save));
        step();
        pc_mux_control = 2'h0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        irq = '0;
        irq_mask_we = 1'b0;
        irq_mask_wdata = '0;
        pc_mux_control = 2'h0;
        pc_next = 11'h20;
        step();
        step();
        #1;
        check("rst_mask", 32'(irq_mask), 32'hFF);
        check("rst_pend", 32'(irq_pending), 0);
        check("rst_isr", 32'(in_isr), 0);
        check("rst_depth", 32'(nest_depth), 0);
        check("rst_id", 32'(active_id), 0);
        check("rst_pc", 32'(pc_out), 32'h20);
        check("rst_save", 32'(pc_save), 0);
        reset_n = 1'b1;

        // 1: single entry and return
        step();
        irq = 8'h08;
        step();
        irq = '0;
        #1;
        check("t1_pend", 32'(irq_pending), 32'h08);
        check("t1_vec", 32'(pc_out), 32'h0A);
        step();
        #1;
        check("t1_pend_clr", 32'(irq_pending), 0);
        check("t1_depth", 32'(nest_depth), 1);
        check("t1_id", 32'(active_id), 3);
        check("t1_isr", 32'(in_isr), 1);
        check("t1_pcthru", 32'(pc_out), 32'h20);
        rfi(11'h20);
        check("t1_ret_depth", 32'(nest_depth), 0);
        check("t1_ret_isr", 32'(in_isr), 0);

        // 2: lower priority waits, higher preempts, LIFO return then tail entry
        enter(3, 11'h20, 11'h0A);
        step();
        irq = 8'h20;
        pc_next = 11'h30;
        step();
        irq = '0;
        #1;
        check("t2_pend5", 32'(irq_pending), 32'h20);
        check("t2_nopre", 32'(pc_out), 32'h30);
        enter(1, 11'h30, 11'h06);
        check("t2_depth2", 32'(nest_depth), 2);
        check("t2_pend5b", 32'(irq_pending), 32'h20);
        rfi(11'h30);
        check("t2_back3", 32'(active_id), 3);
        rfi(11'h20);
        check("t2_vec5", 32'(pc_out), 32'h0E);
        step();
        #1;
        check("t2_id5", 32'(active_id), 5);
        rfi(11'h30);

        // 3: simultaneous requests, rfi blocks entry, tail-chain 0,2,4
        step();
        irq = 8'h15;
        pc_next = 11'h40;
        step();
        irq = '0;
        #1;
        check("t3_pend", 32'(irq_pending), 32'h15);
        check("t3_vec0", 32'(pc_out), 32'h04);
        step();
        #1;
        check("t3_id0", 32'(active_id), 0);
        check("t3_pend2", 32'(irq_pending), 32'h14);
        check("t3_wait", 32'(pc_out), 32'h40);
        step();
        pc_mux_control = 2'h3;
        #1;
        check("t3_save", 32'(pc_save), 32'h40);
        step();
        #1;
        check("t3_rfi0_depth", 32'(nest_depth), 0);
        check("t3_rfi_block", 32'(pc_out), 32'h40);
        check("t3_rfi0_save", 32'(pc_save), 0);
        step();
        pc_mux_control = 2'h0;
        #1;
        check("t3_nodepth", 32'(nest_depth), 0);
        check("t3_vec2", 32'(pc_out), 32'h08);
        step();
        #1;
        check("t3_id2", 32'(active_id), 2);
        check("t3_pend4", 32'(irq_pending), 32'h10);
        step();
        pc_mux_control = 2'h3;
        #1;
        check("t3_rfi_nochain", 32'(pc_out), 32'h40);
        step();
        pc_mux_control = 2'h0;
        #1;
        check("t3_vec4", 32'(pc_out), 32'h0C);
        step();
        #1;
        check("t3_id4", 32'(active_id), 4);
        rfi(11'h40);

        // 4: masked request held, serviced on re-enable
        step();
        irq_mask_we = 1'b1;
        irq_mask_wdata = 8'hBF;
        step();
        irq_mask_we = 1'b0;
        irq = 8'h40;
        #1;
        check("t4_mask", 32'(irq_mask), 32'hBF);
        step();
        irq = '0;
        #1;
        check("t4_pend", 32'(irq_pending), 32'h40);
        check("t4_noentry", 32'(pc_out), 32'h40);
        step();
        irq_mask_we = 1'b1;
        irq_mask_wdata = 8'hFF;
        #1;
        check("t4_held", 32'(irq_pending), 32'h40);
        check("t4_depth0", 32'(nest_depth), 0);
        step();
        irq_mask_we = 1'b0;
        #1;
        check("t4_vec6", 32'(pc_out), 32'h10);
        step();
        #1;
        check("t4_id6", 32'(active_id), 6);
        rfi(11'h40);

        // 5: stack full holds request; rfi at depth 0 is a no-op
        enter(3, 11'h20, 11'h0A);
        enter(1, 11'h30, 11'h06);
        step();
        irq = 8'h01;
        step();
        irq = '0;
        #1;
        check("t5_pend0", 32'(irq_pending), 32'h01);
        check("t5_full", 32'(pc_out), 32'h30);
        check("t5_depth", 32'(nest_depth), 2);
        step();
        #1;
        check("t5_held", 32'(irq_pending), 32'h01);
        rfi(11'h30);
        check("t5_vec0", 32'(pc_out), 32'h04);
        step();
        #1;
        check("t5_id0", 32'(active_id), 0);
        check("t5_depth2", 32'(nest_depth), 2);
        rfi(11'h30);
        rfi(11'h20);
        step();
        pc_mux_control = 2'h3;
        #1;
        check("t5_empty_save", 32'(pc_save), 0);
        step();
        pc_mux_control = 2'h0;
        #1;
        check("t5_empty_depth", 32'(nest_depth), 0);
        check("t5_empty_isr", 32'(in_isr), 0);
        check("t5_empty_pend", 32'(irq_pending), 0);

        // 6: asynchronous reset mid-ISR
        enter(3, 11'h20, 11'h0A);
        enter(1, 11'h30, 11'h06);
        step();
        irq = 8'h60;
        irq_mask_we = 1'b1;
        irq_mask_wdata = 8'h0F;
        step();
        irq = '0;
        irq_mask_we = 1'b0;
        #1;
        check("t6_pend", 32'(irq_pending), 32'h60);
        check("t6_depth", 32'(nest_depth), 2);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_isr", 32'(in_isr), 0);
        check("t6_depth0", 32'(nest_depth), 0);
        check("t6_pend0", 32'(irq_pending), 0);
        check("t6_mask", 32'(irq_mask), 32'hFF);
        check("t6_id", 32'(active_id), 0);
        check("t6_pc", 32'(pc_out), 32'h30);
        step();
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
